sram_like_slave: RTL and testbench

Responder end of the SRAM-like bus used by the fetch and memory stages: accepts req/addr_ok address handshakes, performs each access on a synchronous single-cycle SRAM, and returns data_ok/rdata strictly in request order. Sits between a core-side SRAM-like master port (instruction or data) and a plain SRAM macro. It is also the bus-level model the pipeline benches use, with a stall input for back-pressure testing.

---
 rtl/sram_like_slave.sv | 98 +++++++++
 tb/tb_sram_like_slave.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_slave.sv
// SRAM-like bus responder: address handshake, single-cycle SRAM access,
// in-order data_ok/rdata return through a small response FIFO.
module sram_like_slave #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    input  logic        stall_addr,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          pend_v;
    logic          pend_wr;
    logic [CW-1:0] fifo_cnt;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   fifo_mem [DEPTH];
    logic [OW-1:0] outstanding;
    logic          accept;
    logic          push;
    logic          pop;
    logic          unused_size;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // size is informational; byte lanes come from wstrb
    assign unused_size = ^size;

    assign outstanding = OW'(pend_v) + OW'(fifo_cnt);
    assign data_ok     = (fifo_cnt != '0);
    assign rdata       = fifo_mem[rd_ptr];

    // A response leaving this cycle frees its slot for a new accept
    assign addr_ok = !stall_addr
                   && ((outstanding - OW'(data_ok)) < OW'(DEPTH));
    assign accept  = req && addr_ok && resetn;
    assign push    = pend_v;
    assign pop     = data_ok;

    assign sram_en    = accept;
    assign sram_wen   = (accept && wr) ? wstrb : 4'b0;
    assign sram_addr  = addr;
    assign sram_wdata = wdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_v  <= 1'b0;
            pend_wr <= 1'b0;
        end else begin
            pend_v  <= accept;
            pend_wr <= accept && wr;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= pend_wr ? 32'b0 : sram_rdata;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + CW'(1);
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave: three depths side by side, SRAM macro model,
// in-order response scoreboard plus directed literal expectations.
module tb_sram_like_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             resetn;
    logic [2:0]       req_a, wr_a, stall_a;
    logic [2:0]       addr_ok_a, data_ok_a, sram_en_a;
    logic [2:0][1:0]  size_a;
    logic [2:0][3:0]  wstrb_a, sram_wen_a;
    logic [2:0][31:0] addr_a, wdata_a, rdata_a;
    logic [2:0][31:0] sram_addr_a, sram_wdata_a;
    logic [2:0][31:0] sram_rd = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int D = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        sram_like_slave #(.DEPTH(D)) dut (
            .clk        (clk),
            .resetn     (resetn),
            .req        (req_a[g]),
            .wr         (wr_a[g]),
            .size       (size_a[g]),
            .wstrb      (wstrb_a[g]),
            .addr       (addr_a[g]),
            .wdata      (wdata_a[g]),
            .addr_ok    (addr_ok_a[g]),
            .data_ok    (data_ok_a[g]),
            .rdata      (rdata_a[g]),
            .stall_addr (stall_a[g]),
            .sram_en    (sram_en_a[g]),
            .sram_wen   (sram_wen_a[g]),
            .sram_addr  (sram_addr_a[g]),
            .sram_wdata (sram_wdata_a[g]),
            .sram_rdata (sram_rd[g])
        );
    end

    function automatic int dep(int g);
        return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    // 4 KB SRAM macro per instance; upper address bits alias
    logic [31:0] sram_mem [3][1024];
    logic [31:0] ref_mem  [3][1024];

    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (sram_en_a[g]) begin
                sram_rd[g] <= sram_mem[g][sram_addr_a[g][11:2]];
                for (int b = 0; b < 4; b++) begin
                    if (sram_wen_a[g][b])
                        sram_mem[g][sram_addr_a[g][11:2]][8*b +: 8]
                            <= sram_wdata_a[g][8*b +: 8];
                end
            end
        end
    end

    // Reference: each accepted access yields one response, due no earlier
    // than 2 cycles after accept and one cycle after the previous response.
    typedef struct {
        logic [31:0] data;
        int          due;
    } resp_t;

    resp_t expq [3][$];
    int    last_due [3];
    int    dok_cnt [3];
    int    en_cnt [3];

    always @(negedge clk) begin
        cyc++;
        for (int g = 0; g < 3; g++) begin
            int          n;
            int          due;
            logic        dok;
            logic        aok;
            logic        acc;
            logic [9:0]  wi;
            logic [31:0] d;
            resp_t       r;
            string       p;
            p = $sformatf("d%0d_", dep(g));
            if (!resetn) begin
                expq[g].delete();
                last_due[g] = 0;
                dok_cnt[g] = 0;
                en_cnt[g] = 0;
                chk({p, "rst_data_ok"}, 32'(data_ok_a[g]), 0);
                chk({p, "rst_sram_en"}, 32'(sram_en_a[g]), 0);
                chk({p, "rst_sram_wen"}, 32'(sram_wen_a[g]), 0);
                chk({p, "rst_rdata"}, rdata_a[g], 0);
                chk({p, "rst_addr_ok"}, 32'(addr_ok_a[g]),
                    32'(!stall_a[g]));
            end else begin
                if (data_ok_a[g]) dok_cnt[g]++;
                if (sram_en_a[g]) en_cnt[g]++;
                n = expq[g].size();
                dok = 1'b0;
                if (n > 0) dok = (expq[g][0].due <= cyc);
                chk({p, "data_ok"}, 32'(data_ok_a[g]), 32'(dok));
                if (dok) begin
                    r = expq[g].pop_front();
                    chk({p, "rdata"}, rdata_a[g], r.data);
                end
                aok = !stall_a[g] && ((n - int'(dok)) < dep(g));
                chk({p, "addr_ok"}, 32'(addr_ok_a[g]), 32'(aok));
                acc = req_a[g] && aok;
                chk({p, "sram_en"}, 32'(sram_en_a[g]), 32'(acc));
                chk({p, "sram_wen"}, 32'(sram_wen_a[g]),
                    32'((acc && wr_a[g]) ? wstrb_a[g] : 4'b0));
                if (acc) begin
                    chk({p, "sram_addr"}, sram_addr_a[g], addr_a[g]);
                    chk({p, "sram_wdata"}, sram_wdata_a[g], wdata_a[g]);
                    wi = addr_a[g][11:2];
                    if (wr_a[g]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb_a[g][b])
                                ref_mem[g][wi][8*b +: 8] = wdata_a[g][8*b +: 8];
                        end
                        d = 32'b0;
                    end else begin
                        d = ref_mem[g][wi];
                    end
                    due = cyc + 2;
                    if (last_due[g] + 1 > due) due = last_due[g] + 1;
                    last_due[g] = due;
                    expq[g].push_back('{data: d, due: due});
                end
            end
        end
    end

    task automatic drive_all(input logic r, input logic w,
                             input logic [3:0] s, input logic [31:0] a,
                             input logic [31:0] d);
        for (int g = 0; g < 3; g++) begin
            req_a[g]   = r;
            wr_a[g]    = w;
            size_a[g]  = 2'd2;
            wstrb_a[g] = s;
            addr_a[g]  = a;
            wdata_a[g] = d;
            stall_a[g] = 1'b0;
        end
    endtask

    task automatic next_cycle(input logic r, input logic w,
                              input logic [3:0] s, input logic [31:0] a,
                              input logic [31:0] d);
        @(posedge clk);
        #1;
        drive_all(r, w, s, a, d);
        @(negedge clk);
    endtask

    logic [31:0] t_addr [200];
    logic [31:0] t_data [200];
    logic [3:0]  t_strb [200];
    logic        t_wr   [200];
    int          idx [3];
    logic        done;
    int          guard;

    initial begin
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 1024; i++) begin
                sram_mem[g][i] = 32'hc0de0000 | 32'(i);
                ref_mem[g][i]  = 32'hc0de0000 | 32'(i);
            end
            sram_mem[g][0]     = 32'h3c1d0001;
            ref_mem[g][0]      = 32'h3c1d0001;
            sram_mem[g][10'h40] = 32'haaaaaaaa;
            ref_mem[g][10'h40]  = 32'haaaaaaaa;
        end

        // Reset held with a pending request
        resetn = 1'b0;
        drive_all(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("reset_data_ok", 32'(data_ok_a[1]), 0);
        chk("reset_sram_en", 32'(sram_en_a[1]), 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        drive_all(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("release_addr_ok", 32'(addr_ok_a[1]), 1);

        // Single read, 2-cycle latency
        next_cycle(1'b1, 1'b0, 4'h0, 32'hbfc00000, 32'h0);
        chk("single_sram_en", 32'(sram_en_a[1]), 1);
        chk("single_sram_addr", sram_addr_a[1], 32'hbfc00000);
        next_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("single_t1_data_ok", 32'(data_ok_a[1]), 0);
        next_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("single_t2_data_ok", 32'(data_ok_a[1]), 1);
        chk("single_t2_rdata", rdata_a[1], 32'h3c1d0001);
        next_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("single_t3_data_ok", 32'(data_ok_a[1]), 0);

        // Eight back-to-back reads
        for (int j = 0; j < 12; j++) begin
            next_cycle(j < 8, 1'b0, 4'h0, 32'(4 * j), 32'h0);
            if (j < 8) chk($sformatf("b2b_addr_ok_%0d", j),
                           32'(addr_ok_a[1]), 1);
            chk($sformatf("b2b_data_ok_%0d", j), 32'(data_ok_a[1]),
                32'(j >= 2 && j <= 9));
            if (j == 2) chk("b2b_rdata0", rdata_a[1], 32'h3c1d0001);
            if (j == 3) chk("b2b_rdata1", rdata_a[1], 32'hc0de0001);
        end

        // Partial write then read of the same word
        next_cycle(1'b1, 1'b1, 4'h3, 32'h100, 32'h11223344);
        next_cycle(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        chk("wr_rd_addr_ok", 32'(addr_ok_a[1]), 1);
        next_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("wr_resp_data_ok", 32'(data_ok_a[1]), 1);
        chk("wr_resp_rdata", rdata_a[1], 32'h0);
        next_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("rd_after_wr_data_ok", 32'(data_ok_a[1]), 1);
        chk("rd_after_wr_rdata", rdata_a[1], 32'haaaa3344);
        for (int j = 0; j < 3; j++) next_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Reset with two transactions outstanding
        next_cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        next_cycle(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        drive_all(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("midrst_data_ok_0", 32'(data_ok_a[1]), 0);
        for (int j = 1; j < 4; j++) begin
            next_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            chk($sformatf("midrst_data_ok_%0d", j), 32'(data_ok_a[1]), 0);
        end
        next_cycle(1'b1, 1'b0, 4'h0, 32'hbfc00000, 32'h0);
        next_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("post_rst_t1_data_ok", 32'(data_ok_a[1]), 0);
        next_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("post_rst_t2_data_ok", 32'(data_ok_a[1]), 1);
        chk("post_rst_t2_rdata", rdata_a[1], 32'h3c1d0001);

        // Random traffic with random address stalls
        for (int i = 0; i < 200; i++) begin
            t_wr[i]   = ($urandom_range(0, 2) == 0);
            t_addr[i] = 32'h200 + 32'($urandom_range(0, 31) << 2);
            t_data[i] = $urandom;
            t_strb[i] = 4'($urandom);
        end
        for (int g = 0; g < 3; g++) idx[g] = 0;
        done = 1'b0;
        guard = 0;
        while (!done && guard < 5000) begin
            guard++;
            @(posedge clk);
            #1;
            for (int g = 0; g < 3; g++) begin
                if (idx[g] < 200) begin
                    req_a[g]   = ($urandom_range(0, 3) != 0);
                    wr_a[g]    = t_wr[idx[g]];
                    addr_a[g]  = t_addr[idx[g]];
                    wdata_a[g] = t_data[idx[g]];
                    wstrb_a[g] = t_strb[idx[g]];
                    stall_a[g] = ($urandom_range(0, 2) == 0);
                end else begin
                    req_a[g]   = 1'b0;
                    stall_a[g] = 1'b0;
                end
            end
            @(negedge clk);
            done = 1'b1;
            for (int g = 0; g < 3; g++) begin
                if (req_a[g] && addr_ok_a[g]) idx[g]++;
                if (idx[g] < 200) done = 1'b0;
            end
        end
        chk("rand_all_accepted", 32'(done), 1);
        for (int j = 0; j < 20; j++) next_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("d%0d_accepts", dep(g)), 32'(idx[g]), 200);
            chk($sformatf("d%0d_resp_vs_accept", dep(g)),
                32'(dok_cnt[g]), 32'(en_cnt[g]));
            chk($sformatf("d%0d_pending_left", dep(g)),
                32'(expq[g].size()), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
